// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry and the bit-reversal mapping
// used by the stage chain, the reorder buffer and the benches.
package fft_pkg;

   localparam int CBW_DEFAULT = 3;
   localparam int N           = 1 << CBW_DEFAULT;
   localparam int MAX_CBW     = 16;

   // Reverses the low cbw bits of idx; bits above cbw come back as zero.
   function automatic logic [MAX_CBW-1:0] bitrev(input logic [MAX_CBW-1:0] idx,
                                                  input int cbw);
      logic [MAX_CBW-1:0] r;
      r = '0;
      for (int i = 0; i < cbw; i++) begin
         r[i] = idx[cbw-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered
// output that is cleared by reset and held while no read is issued.
module reorder_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   // Array has no reset so it can map onto distributed or block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed bin order and are
// re-emitted in natural order, one bank filling while the other drains.
module fft_reorder
   import fft_pkg::*;
#(
   parameter int DBW = 4,
   parameter int CBW = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_valid,
   input  logic             din_sync,
   input  logic [2*DBW-1:0] din,
   output logic             dout_valid,
   output logic             dout_last,
   output logic [2*DBW-1:0] dout
);

   localparam int              NPTS     = 1 << CBW;
   localparam int              DW       = 2 * DBW;
   localparam logic [CBW-1:0]  LAST_IDX = CBW'(NPTS - 1);

   logic [CBW-1:0]     wr_cnt_q, wr_cnt_d;
   logic               wr_bank_q, wr_bank_d;
   logic [CBW-1:0]     rd_cnt_q, rd_cnt_d;
   logic               rd_bank_q, rd_bank_d;
   logic               rd_active_q, rd_active_d;
   logic               dout_valid_q, dout_valid_d;
   logic               dout_last_q, dout_last_d;

   logic [CBW-1:0]     wr_idx;
   logic [MAX_CBW-1:0] rev_full;
   logic [CBW-1:0]     wr_addr_idx;
   logic               frame_done;

   // A sync sample restarts the frame at index 0 in the same bank, silently
   // dropping whatever partial frame was there.
   always_comb begin
      wr_idx      = din_sync ? '0 : wr_cnt_q;
      rev_full    = bitrev(MAX_CBW'(wr_idx), CBW);
      wr_addr_idx = rev_full[CBW-1:0];
      frame_done  = din_valid && (wr_idx == LAST_IDX);
   end

   always_comb begin
      wr_cnt_d     = wr_cnt_q;
      wr_bank_d    = wr_bank_q;
      rd_cnt_d     = rd_cnt_q;
      rd_bank_d    = rd_bank_q;
      rd_active_d  = rd_active_q;
      dout_valid_d = rd_active_q;
      dout_last_d  = rd_active_q && (rd_cnt_q == LAST_IDX);

      if (din_valid) begin
         wr_cnt_d = wr_idx + 1'b1;
      end

      if (rd_active_q) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
         if (rd_cnt_q == LAST_IDX) begin
            rd_active_d = 1'b0;
         end
      end

      // A completed frame wins over the end of the previous drain, which is
      // what keeps back-to-back frames gap-free at the output.
      if (frame_done) begin
         wr_bank_d   = ~wr_bank_q;
         rd_bank_d   = wr_bank_q;
         rd_active_d = 1'b1;
         rd_cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_active_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         wr_bank_q    <= wr_bank_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_bank_q    <= rd_bank_d;
         rd_active_q  <= rd_active_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
      end
   end

   reorder_ram #(
      .DW (DW),
      .AW (CBW + 1)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (din_valid),
      .waddr_i ({wr_bank_q, wr_addr_idx}),
      .wdata_i (din),
      .re_i    (rd_active_q),
      .raddr_i ({rd_bank_q, rd_cnt_q}),
      .rdata_o (dout)
   );

   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: table vectors for the basic frame plus
// a scoreboard fed by a bit-reversal frame model for the multi-frame cases.
module tb_fft_reorder;

   localparam int DBW = 4;
   localparam int CBW = 3;
   localparam int NP  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din_valid;
   logic       din_sync;
   logic [7:0] din;
   logic       dout_valid;
   logic       dout_last;
   logic [7:0] dout;

   always #5 clk = ~clk;

   fft_reorder #(
      .DBW (DBW),
      .CBW (CBW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (din_valid),
      .din_sync   (din_sync),
      .din        (din),
      .dout_valid (dout_valid),
      .dout_last  (dout_last),
      .dout       (dout)
   );

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      logic [7:0] din;
      logic       sync;
      logic [7:0] expDout;
      logic       expLast;
   } vec_t;

   exp_t       expQ[$];
   vec_t       vecs[NP];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         validCount = 0;
   int         lastCount = 0;
   int         firstOutCyc = -1;
   int         lastOutCyc = -1;
   logic       modelEn = 1'b0;
   logic [7:0] mFrame[NP];
   int         mCnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic int tbRev(input int k);
      int r;
      r = 0;
      for (int b = 0; b < CBW; b++) begin
         if (k[b]) r = r | (1 << (CBW - 1 - b));
      end
      return r;
   endfunction

   // Scoreboard: every valid output must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (dout_valid) begin
            validCount++;
            if (dout_last) lastCount++;
            if (firstOutCyc < 0) firstOutCyc = cyc;
            lastOutCyc = cyc;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("dout", dout, e.data);
               checkOutput("dout_last", dout_last, e.last);
            end
         end else begin
            checkOutput("last_without_valid", dout_last, 1'b0);
         end
      end
   end

   // Drives one cycle; the frame model places each sample at its reversed bin
   // and queues the whole frame in natural order once index N-1 lands.
   task automatic applyStimulus(input logic [7:0] data, input logic sync, input logic valid);
      int idx;
      exp_t e;
      din       = data;
      din_sync  = sync;
      din_valid = valid;
      if (valid) begin
         idx = sync ? 0 : mCnt;
         mFrame[tbRev(idx)] = data;
         mCnt = (idx + 1) % NP;
         if (idx == NP - 1 && modelEn) begin
            for (int k = 0; k < NP; k++) begin
               e.data = mFrame[k];
               e.last = (k == NP - 1);
               expQ.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      din_sync  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drainWait(input string name, input int maxCyc);
      din_valid = 1'b0;
      din_sync  = 1'b0;
      for (int i = 0; i < maxCyc; i++) begin
         if (expQ.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput({name, "_drained"}, expQ.size(), 32'd0);
      idle(3);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int   v0, l0, tLast;
      exp_t e;
      logic [7:0] rv;
      logic [7:0] revOrder[NP];

      revOrder = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
      for (int i = 0; i < NP; i++) begin
         vecs[i].din     = revOrder[i];
         vecs[i].sync    = (i == 0);
         vecs[i].expDout = 8'(i);
         vecs[i].expLast = (i == NP - 1);
      end

      rst_n     = 1'b0;
      din_valid = 1'b0;
      din_sync  = 1'b0;
      din       = 8'h00;
      #12;
      checkOutput("reset_dout_valid", dout_valid, 1'b0);
      checkOutput("reset_dout_last", dout_last, 1'b0);
      checkOutput("reset_dout", dout, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      $display("[TB] test 1: single frame");
      modelEn = 1'b0;
      firstOutCyc = -1;
      v0 = validCount;
      l0 = lastCount;
      tLast = 0;
      for (int i = 0; i < NP; i++) begin
         e.data = vecs[i].expDout;
         e.last = vecs[i].expLast;
         expQ.push_back(e);
         if (i == NP - 1) tLast = cyc;
         applyStimulus(vecs[i].din, vecs[i].sync, 1'b1);
      end
      drainWait("t1", 20);
      checkOutput("t1_latency", firstOutCyc - tLast, 32'd2);
      checkOutput("t1_span", lastOutCyc - firstOutCyc, 32'd7);
      checkOutput("t1_count", validCount - v0, 32'd8);
      checkOutput("t1_lasts", lastCount - l0, 32'd1);

      $display("[TB] test 2: three frames back to back");
      modelEn = 1'b1;
      firstOutCyc = -1;
      v0 = validCount;
      l0 = lastCount;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NP; i++) begin
            applyStimulus(vecs[i].din + 8'(f * 16), vecs[i].sync, 1'b1);
         end
      end
      drainWait("t2", 40);
      checkOutput("t2_span", lastOutCyc - firstOutCyc, 32'd23);
      checkOutput("t2_count", validCount - v0, 32'd24);
      checkOutput("t2_lasts", lastCount - l0, 32'd3);

      $display("[TB] test 3: half-rate input");
      modelEn = 1'b0;
      firstOutCyc = -1;
      v0 = validCount;
      for (int i = 0; i < NP; i++) begin
         e.data = vecs[i].expDout;
         e.last = vecs[i].expLast;
         expQ.push_back(e);
         if (i == NP - 1) tLast = cyc;
         applyStimulus(vecs[i].din, vecs[i].sync, 1'b1);
         if (i != NP - 1) applyStimulus(8'hFF, 1'b0, 1'b0);
      end
      drainWait("t3", 20);
      checkOutput("t3_latency", firstOutCyc - tLast, 32'd2);
      checkOutput("t3_span", lastOutCyc - firstOutCyc, 32'd7);
      checkOutput("t3_count", validCount - v0, 32'd8);

      $display("[TB] test 4: mid-frame sync");
      modelEn = 1'b1;
      v0 = validCount;
      l0 = lastCount;
      for (int i = 0; i < 4; i++) applyStimulus(8'hE0 + 8'(i), (i == 0), 1'b1);
      for (int i = 0; i < NP; i++) applyStimulus(8'h30 + vecs[i].din, vecs[i].sync, 1'b1);
      drainWait("t4", 20);
      checkOutput("t4_count", validCount - v0, 32'd8);
      checkOutput("t4_lasts", lastCount - l0, 32'd1);

      $display("[TB] test 5: reset during drain");
      v0 = validCount;
      for (int i = 0; i < NP; i++) applyStimulus(8'h40 + vecs[i].din, vecs[i].sync, 1'b1);
      din_valid = 1'b0;
      din_sync  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (validCount - v0 >= 4) break;
      end
      checkOutput("t5_reach_4th", validCount - v0, 32'd4);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_async_valid", dout_valid, 1'b0);
      checkOutput("t5_async_dout", dout, 8'h00);
      checkOutput("t5_async_last", dout_last, 1'b0);
      expQ.delete();
      mCnt = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2);
      v0 = validCount;
      idle(20);
      checkOutput("t5_silent_after_reset", validCount - v0, 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i), 1'b0, 1'b1);
      idle(20);
      checkOutput("t5_silent_partial", validCount - v0, 32'd0);
      l0 = lastCount;
      for (int i = 0; i < NP; i++) applyStimulus(8'h50 + vecs[i].din, vecs[i].sync, 1'b1);
      drainWait("t5", 20);
      checkOutput("t5_count", validCount - v0, 32'd8);
      checkOutput("t5_lasts", lastCount - l0, 32'd1);

      $display("[TB] test 6: random frames with gaps");
      v0 = validCount;
      l0 = lastCount;
      for (int f = 0; f < 100; f++) begin
         for (int s = 0; s < NP; s++) begin
            while ($urandom_range(3) == 0) applyStimulus(8'($urandom), 1'b0, 1'b0);
            rv = 8'($urandom);
            applyStimulus(rv, (s == 0) ? 1'($urandom_range(1)) : 1'b0, 1'b1);
         end
      end
      drainWait("t6", 40);
      checkOutput("t6_count", validCount - v0, 32'd800);
      checkOutput("t6_lasts", lastCount - l0, 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
